ps2_key_encoder: RTL and testbench

//  Producer end of the 11-bit ps2_key event bus consumed by the core keyboard decoders.

---
 rtl/ps2_pkg.sv | 38 +++
 rtl/ps2_rx_frame.sv | 101 ++++++++++
 rtl/ps2_key_encoder.sv | 113 +++++++++++
 tb/tb_ps2_key_encoder.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 key-event types, prefix codes and the list of non-key bytes.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ps2_pkg;

  localparam logic [7:0] PS2_PFX_EXT   = 8'hE0;
  localparam logic [7:0] PS2_PFX_BRK   = 8'hF0;
  localparam logic [7:0] PS2_PFX_PAUSE = 8'hE1;
  localparam int unsigned PS2_PAUSE_LEN = 7;

  // Keyboard status/ack/error bytes that never map to a key.
  localparam int PS2_NUM_DROP = 7;
  localparam logic [PS2_NUM_DROP*8-1:0] PS2_DROP_CODES =
    {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF};

  typedef struct packed {
    logic       toggle;
    logic       pressed;
    logic       ext;
    logic [7:0] code;
  } ps2_key_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PFX,
    ST_PAUSE
  } dec_state_e;

  function automatic logic ps2_is_drop(input logic [7:0] b);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < PS2_NUM_DROP; i++) begin
      if (PS2_DROP_CODES[i*8 +: 8] == b) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 device->host receiver: sync, clock glitch filter, 11-bit deserialiser, idle timeout.
// Latency: byte_vld_o rises 1 cycle after the filtered falling edge of the stop bit.
// Backpressure: none; byte_vld_o/err_o are single-cycle pulses that must be taken when seen.
module ps2_rx_frame #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 24576
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic [7:0] byte_o,
  output logic       byte_vld_o,
  output logic       err_o
);

  localparam int FCW = $clog2(FILTER_LEN + 1);
  localparam int IW  = $clog2(TIMEOUT_CYC + 1);

  logic [1:0]     clk_sync_q, dat_sync_q;
  logic           filt_q;
  logic [FCW-1:0] fcnt_q;
  logic [3:0]     bit_cnt_q;
  logic [9:0]     shift_q;
  logic [IW-1:0]  idle_q;
  logic [7:0]     byte_q;
  logic           byte_vld_q, err_q;

  logic raw_clk, raw_dat, flip, fall, frame_ok;

  assign raw_clk = clk_sync_q[1];
  assign raw_dat = dat_sync_q[1];
  // Filtered clock flips on the FILTER_LEN-th consecutive sample that disagrees with it.
  assign flip    = (raw_clk != filt_q) && (fcnt_q == FCW'(FILTER_LEN - 1));
  assign fall    = flip && filt_q;
  // shift_q holds {parity, D7..D0, start}; raw_dat is the stop bit on the 11th edge.
  assign frame_ok = !shift_q[0] && (^shift_q[9:1]) && raw_dat;

  // Two-flop synchronisers; lines idle high.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
    end else begin
      clk_sync_q <= {clk_sync_q[0], ps2_clk_i};
      dat_sync_q <= {dat_sync_q[0], ps2_data_i};
    end
  end

  // Glitch filter: any agreeing sample restarts the disagreement run.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      filt_q <= 1'b1;
      fcnt_q <= '0;
    end else if (raw_clk == filt_q) begin
      fcnt_q <= '0;
    end else if (flip) begin
      filt_q <= raw_clk;
      fcnt_q <= '0;
    end else begin
      fcnt_q <= fcnt_q + 1'b1;
    end
  end

  // Deserialiser, frame checks and idle timeout of a partially received frame.
  always_ff @(posedge clk_i) begin
    byte_vld_q <= 1'b0;
    err_q      <= 1'b0;
    if (rst_i) begin
      bit_cnt_q <= '0;
      shift_q   <= '0;
      idle_q    <= '0;
      byte_q    <= '0;
    end else if (fall) begin
      idle_q <= '0;
      if (bit_cnt_q == 4'd10) begin
        bit_cnt_q <= '0;
        if (frame_ok) begin
          byte_q     <= shift_q[8:1];
          byte_vld_q <= 1'b1;
        end else begin
          err_q <= 1'b1;
        end
      end else begin
        shift_q   <= {raw_dat, shift_q[9:1]};
        bit_cnt_q <= bit_cnt_q + 1'b1;
      end
    end else if (idle_q != IW'(TIMEOUT_CYC)) begin
      idle_q <= idle_q + 1'b1;
      if (idle_q == IW'(TIMEOUT_CYC - 1) && bit_cnt_q != 4'd0) begin
        err_q     <= 1'b1;
        bit_cnt_q <= '0;
      end
    end
  end

  assign byte_o     = byte_q;
  assign byte_vld_o = byte_vld_q;
  assign err_o      = err_q;

endmodule

// File: rtl/ps2_key_encoder.sv
// PS/2 scan-code set 2 to 11-bit key event: folds E0/F0 prefixes, skips the E1 pause sequence.
// Latency: ps2_key/key_stb update 2 cycles after the filtered stop-bit edge.
// Backpressure: none; consumers watch bit 10 toggle or key_stb, events are never held off.
module ps2_key_encoder
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 24576
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [10:0] ps2_key,
  output logic        key_stb,
  output logic        frame_err
);

  logic [7:0] rx_byte;
  logic       rx_vld, rx_err;

  ps2_rx_frame #(
    .FILTER_LEN (FILTER_LEN),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_rx (
    .clk_i     (clk_sys),
    .rst_i     (reset),
    .ps2_clk_i (ps2_clk),
    .ps2_data_i(ps2_data),
    .byte_o    (rx_byte),
    .byte_vld_o(rx_vld),
    .err_o     (rx_err)
  );

  dec_state_e state_q, state_d;
  logic       ext_q, ext_d, brk_q, brk_d;
  logic [2:0] skip_q, skip_d;
  logic       emit_d;
  ps2_key_t   key_q;
  logic       stb_q;

  // Decoder state, prefix flags and pause skip counter.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ext_q   <= 1'b0;
      brk_q   <= 1'b0;
      skip_q  <= '0;
    end else begin
      state_q <= state_d;
      ext_q   <= ext_d;
      brk_q   <= brk_d;
      skip_q  <= skip_d;
    end
  end

  // Next-state: frame errors never reach here, so prefixes survive them.
  always_comb begin
    state_d = state_q;
    ext_d   = ext_q;
    brk_d   = brk_q;
    skip_d  = skip_q;
    emit_d  = 1'b0;
    if (rx_vld) begin
      case (state_q)
        ST_PAUSE: begin
          skip_d = skip_q - 1'b1;
          if (skip_q == 3'd1) state_d = ST_IDLE;
        end
        default: begin
          if (rx_byte == PS2_PFX_EXT) begin
            ext_d   = 1'b1;
            state_d = ST_PFX;
          end else if (rx_byte == PS2_PFX_BRK) begin
            brk_d   = 1'b1;
            state_d = ST_PFX;
          end else if (rx_byte == PS2_PFX_PAUSE) begin
            skip_d  = 3'(PS2_PAUSE_LEN);
            ext_d   = 1'b0;
            brk_d   = 1'b0;
            state_d = ST_PAUSE;
          end else begin
            emit_d  = !ps2_is_drop(rx_byte);
            ext_d   = 1'b0;
            brk_d   = 1'b0;
            state_d = ST_IDLE;
          end
        end
      endcase
    end
  end

  // Event register: flags sampled before this byte cleared them.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      key_q <= '0;
      stb_q <= 1'b0;
    end else begin
      stb_q <= emit_d;
      if (emit_d) begin
        key_q.toggle  <= ~key_q.toggle;
        key_q.pressed <= ~brk_q;
        key_q.ext     <= ext_q;
        key_q.code    <= rx_byte;
      end
    end
  end

  assign ps2_key   = key_q;
  assign key_stb   = stb_q;
  assign frame_err = rx_err;

endmodule

// File: tb/tb_ps2_key_encoder.sv
// Directed plus randomized bench for ps2_key_encoder with a byte-level reference model.
// Latency: stb is expected a fixed small window after the raw stop-bit falling edge.
// Backpressure: n/a.
module tb_ps2_key_encoder;

  localparam int FILTER_LEN  = 8;
  localparam int TIMEOUT_CYC = 24576;
  localparam int HALF        = 12;
  localparam int SETTLE      = 40;

  logic        clk_sys = 1'b0;
  logic        reset   = 1'b1;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic [10:0] ps2_key;
  logic        key_stb, frame_err;

  ps2_key_encoder #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .ps2_key  (ps2_key),
    .key_stb  (key_stb),
    .frame_err(frame_err)
  );

  always #5 clk_sys = ~clk_sys;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int stb_cnt = 0;
  int err_cnt = 0;
  int last_stb_cyc = 0;
  int stop_cyc = 0;

  always @(posedge clk_sys) cyc++;

  always @(negedge clk_sys) begin
    if (key_stb) begin
      stb_cnt++;
      last_stb_cyc = cyc;
    end
    if (frame_err) err_cnt++;
  end

  initial begin
    #(90000 * 10);
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  // Reference model: key-event semantics of a scan-code byte stream.
  bit          m_ext, m_brk;
  int          m_skip;
  logic [10:0] m_key;

  task automatic model_reset();
    m_ext = 0; m_brk = 0; m_skip = 0; m_key = '0;
  endtask

  task automatic model_byte(input logic [7:0] b, output bit emit);
    emit = 0;
    if (m_skip > 0) m_skip--;
    else if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else if (b == 8'hE1) begin
      m_skip = 7; m_ext = 0; m_brk = 0;
    end else begin
      if (!(b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF})) begin
        emit  = 1;
        m_key = {~m_key[10], ~m_brk, m_ext, b};
      end
      m_ext = 0; m_brk = 0;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk_sys);
    reset = 1'b0;
    model_reset();
  endtask

  // Drives bits[0] first; data changes while the clock is high.
  task automatic send_bits(input logic [10:0] bits, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      ps2_data = bits[i];
      repeat (HALF) @(negedge clk_sys);
      ps2_clk  = 1'b0;
      stop_cyc = cyc;
      repeat (HALF) @(negedge clk_sys);
      ps2_clk  = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] b, input bit bad_par);
    logic par;
    par = ~(^b) ^ bad_par;
    return {1'b1, par, b, 1'b0};
  endfunction

  task automatic send_and_check(input logic [7:0] b, input bit bad_par, input string tag);
    int  stb0, err0, lat;
    bit  emit;
    stb0 = stb_cnt;
    err0 = err_cnt;
    send_bits(mk_frame(b, bad_par), 11);
    repeat (SETTLE) @(negedge clk_sys);
    emit = 0;
    if (!bad_par) model_byte(b, emit);
    check({tag, "/stb"}, stb_cnt - stb0, emit ? 1 : 0);
    check({tag, "/err"}, err_cnt - err0, bad_par ? 1 : 0);
    check({tag, "/key"}, 32'(ps2_key), 32'(m_key));
    if (emit) begin
      lat = last_stb_cyc - stop_cyc;
      check({tag, "/lat"}, (lat >= FILTER_LEN + 2 && lat <= FILTER_LEN + 5) ? 1 : 0, 1);
    end
  endtask

  logic [7:0] drops [7] = '{8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF};
  logic [7:0] pause_seq [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};

  initial begin
    int stb0, err0, r;
    logic [7:0] b;
    bit bad;

    // Reset state
    model_reset();
    repeat (4) @(negedge clk_sys);
    reset = 1'b0;
    @(negedge clk_sys);
    check("rst/key", 32'(ps2_key), 0);
    check("rst/stb", 32'(key_stb), 0);
    check("rst/err", 32'(frame_err), 0);

    // Make, break, extended and both prefix orders
    send_and_check(8'h1C, 0, "make1C");
    check("make1C/abs", 32'(ps2_key), 32'h61C);
    send_and_check(8'hF0, 0, "brk_pfx");
    send_and_check(8'h1C, 0, "brk1C");
    check("brk1C/abs", 32'(ps2_key), 32'h01C);
    send_and_check(8'hE0, 0, "e0");
    send_and_check(8'h75, 0, "ext75");
    check("ext75/abs", 32'(ps2_key), 32'h775);
    send_and_check(8'hE0, 0, "e0b");
    send_and_check(8'hF0, 0, "f0b");
    send_and_check(8'h75, 0, "extbrk75");
    check("extbrk75/abs", 32'(ps2_key), 32'h175);
    send_and_check(8'hF0, 0, "f0c");
    send_and_check(8'hE0, 0, "e0c");
    send_and_check(8'h75, 0, "brkext75");
    check("brkext75/abs", 32'(ps2_key), 32'h575);

    // Parity error, then good byte; error inside a prefix keeps the prefix
    send_and_check(8'h29, 1, "par29");
    send_and_check(8'h29, 0, "good29");
    send_and_check(8'hE0, 0, "e0d");
    send_and_check(8'h33, 1, "pfx_par");
    send_and_check(8'h75, 0, "pfx_kept");

    // Partial frame timeout
    stb0 = stb_cnt;
    err0 = err_cnt;
    send_bits(mk_frame(8'h1C, 0), 5);
    repeat (TIMEOUT_CYC + 10) @(negedge clk_sys);
    check("tmo/err", err_cnt - err0, 1);
    check("tmo/stb", stb_cnt - stb0, 0);
    send_and_check(8'h1C, 0, "after_tmo");

    // Reset mid-prefix
    send_and_check(8'hE0, 0, "e0_prerst");
    do_reset();
    send_and_check(8'h1C, 0, "rst_pfx");
    check("rst_pfx/abs", 32'(ps2_key), 32'h61C);

    // Pause/Break sequence emits nothing, next key does
    stb0 = stb_cnt;
    for (int i = 0; i < 8; i++) send_and_check(pause_seq[i], 0, "pause");
    check("pause/nostb", stb_cnt - stb0, 0);
    send_and_check(8'h1C, 0, "post_pause");

    // Short clock glitches must not be sampled
    stb0 = stb_cnt;
    err0 = err_cnt;
    for (int i = 0; i < 4; i++) begin
      ps2_clk = 1'b0;
      repeat (3) @(negedge clk_sys);
      ps2_clk = 1'b1;
      repeat (10) @(negedge clk_sys);
    end
    check("glitch/stb", stb_cnt - stb0, 0);
    check("glitch/err", err_cnt - err0, 0);
    send_and_check(8'h1C, 0, "post_glitch");

    // Randomized byte stream against the model
    for (int n = 0; n < 40; n++) begin
      r   = $urandom_range(0, 9);
      bad = 0;
      case (r)
        0: b = 8'hE0;
        1: b = 8'hF0;
        2: b = drops[$urandom_range(0, 6)];
        3: begin b = 8'($urandom_range(0, 255)); bad = 1; end
        4: b = ($urandom_range(0, 3) == 0) ? 8'hE1 : 8'($urandom_range(0, 255));
        default: b = 8'($urandom_range(0, 255));
      endcase
      send_and_check(b, bad, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
